// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: bursts bytes from a TX FIFO through an external SPI byte
// engine and collects the returned bytes in an RX FIFO.
// Optional feature macro: SPI_BURST_AUTO_CS_EN. When it is defined, chip
// select is driven low automatically for the whole burst and a CS setup delay
// is inserted. When it is undefined, cs_n follows cs_force only and the
// setup state is skipped.
module spi_burst_ctrl #(
    parameter int FIFO_DEPTH    = 4,   // power of two, 2..16
    parameter int CS_SETUP_CLKS = 2    // must be at least 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       tx_full,
    output logic [7:0] rd_data,
    input  logic       rd_en,
    output logic       rx_empty,
    output logic       rx_overflow,
    input  logic       clr_ovf,
    input  logic       cs_force,
    output logic       cs_n,
    output logic       busy,
    output logic [7:0] spi_in_byte,
    output logic       spi_start,
    input  logic       spi_done,
    input  logic [7:0] spi_out_byte
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CS_SETUP_CLKS > 1) ? $clog2(CS_SETUP_CLKS) : 1;
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_BUSY, WAIT_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    spi_in_q, spi_in_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;

    logic tx_empty, tx_push, tx_pop;
    logic rx_full, rx_push, rx_pop, rx_capture, ovf_set;

    // TX side: a pop happens in START; a push into a full FIFO is accepted only alongside that pop
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign tx_pop   = (state_q == START) && !tx_empty;
    assign tx_push  = wr_en && (!tx_full || tx_pop);
    assign tx_cnt_d = tx_cnt_q + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};

    // RX side: a returned byte is captured when the engine reports done in WAIT_DONE
    assign rx_empty   = (rx_cnt_q == '0);
    assign rx_full    = (rx_cnt_q == DEPTH_C);
    assign rx_pop     = rd_en && !rx_empty;
    assign rx_capture = (state_q == WAIT_DONE) && spi_done;
    assign rx_push    = rx_capture && (!rx_full || rx_pop);
    assign ovf_set    = rx_capture && rx_full && !rx_pop;
    assign rx_cnt_d   = rx_cnt_q + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
    assign ovf_d      = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    assign rd_data     = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
    assign rx_overflow = ovf_q;
    assign cs_n        = cs_n_q;
    assign busy        = (state_q != IDLE);
    assign spi_start   = (state_q == START);
    assign spi_in_byte = spi_in_q;

    // Next-state logic for the burst sequencer, chip select and engine byte
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        spi_in_d = spi_in_q;
        case (state_q)
            IDLE: begin
                if (!tx_empty && spi_done) begin
`ifdef SPI_BURST_AUTO_CS_EN
                    if (cs_n_q) begin
                        state_d = SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = START;
                    end
`else
                    state_d = START;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = START;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!spi_done) state_d = WAIT_DONE;
            WAIT_DONE: if (spi_done)  state_d = tx_empty ? IDLE : START;
            default:   state_d = IDLE;
        endcase
        // Latch the TX head on entry to START; it stays put until the next START
        if (state_d == START) spi_in_d = tx_mem_q[tx_rp_q];
`ifdef SPI_BURST_AUTO_CS_EN
        cs_n_d = !((state_d != IDLE) || cs_force);
`else
        cs_n_d = !cs_force;
`endif
    end

    // Control and pointer registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cs_n_q   <= 1'b1;
            spi_in_q <= 8'h00;
            ovf_q    <= 1'b0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_n_q   <= cs_n_d;
            spi_in_q <= spi_in_d;
            ovf_q    <= ovf_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // FIFO storage; contents are qualified by the counts, so no reset is needed
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wr_data;
        if (rx_push) rx_mem_q[rx_wp_q] <= spi_out_byte;
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed testbench for spi_burst_ctrl with a simple SPI engine model
// that returns (sent byte ^ 0x99) three cycles after each start pulse.
module tb_spi_burst_ctrl;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx_full;
    logic [7:0] rd_data;
    logic       rd_en = 1'b0;
    logic       rx_empty;
    logic       rx_overflow;
    logic       clr_ovf = 1'b0;
    logic       cs_force = 1'b0;
    logic       cs_n;
    logic       busy;
    logic [7:0] spi_in_byte;
    logic       spi_start;
    logic       spi_done;
    logic [7:0] spi_out_byte;
    logic       eng_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_burst_ctrl #(.FIFO_DEPTH(4), .CS_SETUP_CLKS(2)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .tx_full(tx_full), .rd_data(rd_data), .rd_en(rd_en), .rx_empty(rx_empty),
        .rx_overflow(rx_overflow), .clr_ovf(clr_ovf), .cs_force(cs_force),
        .cs_n(cs_n), .busy(busy), .spi_in_byte(spi_in_byte), .spi_start(spi_start),
        .spi_done(spi_done), .spi_out_byte(spi_out_byte)
    );

    always #5 clk = ~clk;

    // Engine model: drops done after a start, raises it LAT cycles later with the reply
    initial begin
        int bcnt;
        logic [7:0] lb;
        bcnt = 0;
        lb = 8'h00;
        spi_done = 1'b1;
        spi_out_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    spi_done = 1'b1;
                    spi_out_byte = lb ^ 8'h99;
                end
            end else if (spi_start === 1'b1) begin
                lb = spi_in_byte;
                spi_done = 1'b0;
                bcnt = LAT;
            end else begin
                spi_done = !eng_stall;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (tx_full !== 1'b0)     begin errors++; $display("FAIL reset_tx_full: got %b, expected 0", tx_full); end
        checks++; if (rx_empty !== 1'b1)    begin errors++; $display("FAIL reset_rx_empty: got %b, expected 1", rx_empty); end
        checks++; if (rd_data !== 8'h00)    begin errors++; $display("FAIL reset_rd_data: got %h, expected 00", rd_data); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_rx_overflow: got %b, expected 0", rx_overflow); end
        checks++; if (cs_n !== 1'b1)        begin errors++; $display("FAIL reset_cs_n: got %b, expected 1", cs_n); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (spi_start !== 1'b0)   begin errors++; $display("FAIL reset_spi_start: got %b, expected 0", spi_start); end
        checks++; if (spi_in_byte !== 8'h00) begin errors++; $display("FAIL reset_spi_in_byte: got %h, expected 00", spi_in_byte); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n, start_n, busy_n, cs_n_low_at;
        logic found, cs_low_seen;
        int exp_start_n;
        n = 0; start_n = -1; busy_n = -1; cs_n_low_at = -1;
        found = 1'b0; cs_low_seen = 1'b0;
        cs_force = 1'b0;
        write_byte(8'hA5);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n++;
            if (cs_n === 1'b0 && !cs_low_seen) begin cs_low_seen = 1'b1; cs_n_low_at = n; end
            if (busy === 1'b1 && busy_n < 0) busy_n = n;
            if (spi_start === 1'b1) begin found = 1'b1; start_n = n; end
        end
`ifdef SPI_BURST_AUTO_CS_EN
        exp_start_n = 3;
        checks++; if (start_n - cs_n_low_at !== 2) begin errors++; $display("FAIL single_cs_setup: got %0d, expected 2", start_n - cs_n_low_at); end
`else
        exp_start_n = 1;
        checks++; if (start_n !== busy_n) begin errors++; $display("FAIL single_start_after_idle: start at %0d, busy at %0d", start_n, busy_n); end
`endif
        checks++; if (start_n !== exp_start_n) begin errors++; $display("FAIL single_start_latency: got %0d, expected %0d", start_n, exp_start_n); end
        checks++; if (spi_in_byte !== 8'hA5) begin errors++; $display("FAIL single_spi_in_byte: got %h, expected a5", spi_in_byte); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (cs_n === 1'b0 && !cs_low_seen) cs_low_seen = 1'b1;
            if (rx_empty === 1'b0) found = 1'b1;
        end
        checks++; if (found !== 1'b1)   begin errors++; $display("FAIL single_rx_timeout: rx_empty stayed %b", rx_empty); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL single_rd_data: got %h, expected 3c", rd_data); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
        checks++; if (cs_n !== 1'b1)    begin errors++; $display("FAIL single_cs_n_end: got %b, expected 1", cs_n); end
`ifndef SPI_BURST_AUTO_CS_EN
        checks++; if (cs_low_seen !== 1'b0) begin errors++; $display("FAIL single_cs_stays_high: got low=%b, expected 0", cs_low_seen); end
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_rx_drained: got %b, expected 1", rx_empty); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_rd_data_empty: got %h, expected 00", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent [3];
        logic [7:0] exp_rx [3];
        int at [3];
        int starts, n;
        logic cs_bad, gap_bad;
        exp_rx[0] = 8'h98; exp_rx[1] = 8'h9B; exp_rx[2] = 8'h9A;
        starts = 0; n = 0; cs_bad = 1'b0; gap_bad = 1'b0;
        for (int k = 0; k < 3; k++) begin sent[k] = 8'h00; at[k] = 0; end
`ifndef SPI_BURST_AUTO_CS_EN
        cs_force = 1'b1;
        tick();
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL burst_cs_force: got %b, expected 0", cs_n); end
`endif
        eng_stall = 1'b1;
        tick(); tick();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        eng_stall = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            n++;
            if (spi_start === 1'b1 && starts < 3) begin
                sent[starts] = spi_in_byte;
                at[starts] = n;
                starts++;
            end
            if (busy === 1'b1 && cs_n !== 1'b0) cs_bad = 1'b1;
            if (starts > 0 && starts < 3 && busy !== 1'b1) gap_bad = 1'b1;
            if (starts == 3 && busy === 1'b0) break;
        end
        checks++; if (starts !== 3) begin errors++; $display("FAIL burst_start_count: got %0d, expected 3", starts); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (sent[k] !== 8'(k + 1)) begin errors++; $display("FAIL burst_spi_in_byte%0d: got %h, expected %h", k, sent[k], 8'(k + 1)); end
        end
        checks++; if (at[1] - at[0] !== 4) begin errors++; $display("FAIL burst_spacing1: got %0d, expected 4", at[1] - at[0]); end
        checks++; if (at[2] - at[1] !== 4) begin errors++; $display("FAIL burst_spacing2: got %0d, expected 4", at[2] - at[1]); end
        checks++; if (cs_bad !== 1'b0)  begin errors++; $display("FAIL burst_cs_low: got glitch=%b, expected 0", cs_bad); end
        checks++; if (gap_bad !== 1'b0) begin errors++; $display("FAIL burst_continuous: got gap=%b, expected 0", gap_bad); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rd_data !== exp_rx[k]) begin errors++; $display("FAIL burst_rx%0d: got %h, expected %h", k, rd_data, exp_rx[k]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL burst_rx_drained: got %b, expected 1", rx_empty); end
        cs_force = 1'b0;
        tick(); tick();
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL burst_cs_release: got %b, expected 1", cs_n); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_rx [4];
        int starts;
        logic late_wr;
        exp_rx[0] = 8'h89; exp_rx[1] = 8'h88; exp_rx[2] = 8'h8B; exp_rx[3] = 8'h8A;
        starts = 0; late_wr = 1'b0;
        eng_stall = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) write_byte(8'h10 + 8'(k));
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_tx_full: got %b, expected 1", tx_full); end
        eng_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            wr_en = 1'b0;
            if (spi_start === 1'b1) begin
                starts++;
                if (!late_wr) begin
                    // Fifth byte lands on the cycle the first byte is popped
                    late_wr = 1'b1;
                    wr_data = 8'h14;
                    wr_en = 1'b1;
                end
            end
            if (starts == 5 && busy === 1'b0) break;
        end
        wr_en = 1'b0;
        checks++; if (starts !== 5) begin errors++; $display("FAIL ovf_start_count: got %0d, expected 5", starts); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", rx_overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_data !== exp_rx[k]) begin errors++; $display("FAIL ovf_rx%0d: got %h, expected %h", k, rd_data, exp_rx[k]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_rx_drained: got %b, expected 1", rx_empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL ovf_pop_empty: got empty=%b data=%h, expected 1/00", rx_empty, rd_data); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", rx_overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", rx_overflow); end
    endtask

    task automatic test_tx_full();
        logic [7:0] sent [5];
        logic [7:0] exp_rx [4];
        int starts;
        exp_rx[0] = 8'hB9; exp_rx[1] = 8'hB8; exp_rx[2] = 8'hBB; exp_rx[3] = 8'hBA;
        starts = 0;
        for (int k = 0; k < 5; k++) sent[k] = 8'h00;
        eng_stall = 1'b1;
        tick(); tick();
        for (int k = 0; k < 5; k++) write_byte(8'h20 + 8'(k));
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL txfull_flag: got %b, expected 1", tx_full); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL txfull_idle: got busy=%b, expected 0", busy); end
        eng_stall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (spi_start === 1'b1) begin
                if (starts < 5) sent[starts] = spi_in_byte;
                starts++;
            end
        end
        checks++; if (starts !== 4) begin errors++; $display("FAIL txfull_start_count: got %0d, expected 4", starts); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sent[k] !== 8'h20 + 8'(k)) begin errors++; $display("FAIL txfull_byte%0d: got %h, expected %h", k, sent[k], 8'h20 + 8'(k)); end
        end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL txfull_drained: got %b, expected 0", tx_full); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_data !== exp_rx[k]) begin errors++; $display("FAIL txfull_rx%0d: got %h, expected %h", k, rd_data, exp_rx[k]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL txfull_rx_drained: got %b, expected 1", rx_empty); end
    endtask

    task automatic test_reset_mid_burst();
        logic found;
        int starts;
        found = 1'b0; starts = 0;
`ifndef SPI_BURST_AUTO_CS_EN
        cs_force = 1'b1;
`endif
        tick();
        write_byte(8'h77);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (spi_start === 1'b1) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_start_timeout: no spi_start seen"); end
        tick(); tick();
        checks++; if (busy !== 1'b1 || cs_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_burst: got busy=%b cs_n=%b, expected 1/0", busy, cs_n); end
        reset = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL rstmid_cs_n: got %b, expected 1", cs_n); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rstmid_rx_empty: got %b, expected 1", rx_empty); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        tick(); tick();
        reset = 1'b1;
        cs_force = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (spi_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0)      begin errors++; $display("FAIL rstmid_no_start: got %0d starts, expected 0", starts); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rstmid_rx_after: got %b, expected 1", rx_empty); end
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL rstmid_cs_after: got %b, expected 1", cs_n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_tx_full();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
